// File: rtl/cnn_pkg.sv
// Types and helpers shared by the CNN stream stages.
package cnn_pkg;

  localparam int unsigned WIDTH = 16;

  typedef logic signed [WIDTH-1:0] sample_t;

  function automatic sample_t relu(input sample_t x);
    return x[WIDTH-1] ? '0 : x;
  endfunction

endpackage

// File: rtl/relu_pool_fifo.sv
// Synchronous FIFO with full/empty flags; the head entry is read straight from storage flops.
module relu_pool_fifo #(
  parameter int unsigned W     = 17,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  output logic         full,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("relu_pool_fifo: DEPTH must be a power of two >= 2");
  end

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          push_ok, pop_ok;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  // A push into a full FIFO is refused even if a pop happens in the same cycle.
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

endmodule

// File: rtl/relu_maxpool_stream.sv
// ReLU followed by non-overlapping 1-D max-pooling over a streamed conv output vector,
// buffered in a small FIFO and forwarded on a valid/ready stream with an end-of-vector flag.
module relu_maxpool_stream
  import cnn_pkg::*;
#(
  parameter int unsigned WIDTH  = cnn_pkg::WIDTH,
  parameter int unsigned LENIN  = 24,
  parameter int unsigned POOL   = 2,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned LOGLEN = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] s_data_in_x,
  input  logic             s_valid_x,
  output logic             s_ready_x,
  output logic [WIDTH-1:0] m_data_out_y,
  output logic             m_valid_y,
  input  logic             m_ready_y,
  output logic             m_last_y
);

  localparam int unsigned LENOUT = LENIN / POOL;

  if ((POOL == 0) || (LENIN % POOL != 0)) begin : g_bad_pool
    $error("relu_maxpool_stream: LENIN must be a multiple of POOL");
  end
  if ((64'd1 << LOGLEN) < 64'(LENIN)) begin : g_bad_loglen
    $error("relu_maxpool_stream: LOGLEN too small for LENIN");
  end

  logic [LOGLEN-1:0]       pool_cnt, out_cnt;
  logic signed [WIDTH-1:0] run_max, relu_x, new_max;
  logic                    completing, last_out, xfer, push, fifo_full, fifo_empty;
  logic [WIDTH:0]          head;

  if (WIDTH == cnn_pkg::WIDTH) begin : g_pkg_relu
    assign relu_x = relu(sample_t'(s_data_in_x));
  end else begin : g_local_relu
    assign relu_x = s_data_in_x[WIDTH-1] ? '0 : $signed(s_data_in_x);
  end

  assign completing = (pool_cnt == LOGLEN'(POOL - 1));
  assign last_out   = (out_cnt == LOGLEN'(LENOUT - 1));

  // Depends only on registered state, so m_ready_y never reaches s_ready_x combinationally.
  assign s_ready_x = !completing || !fifo_full;
  assign xfer      = s_valid_x && s_ready_x;
  assign push      = xfer && completing;

  // The pushed value must include the sample arriving with the push.
  always_comb begin
    new_max = relu_x;
    if ((pool_cnt != '0) && (run_max > relu_x)) begin
      new_max = run_max;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pool_cnt <= '0;
      out_cnt  <= '0;
      run_max  <= '0;
    end else if (xfer) begin
      run_max  <= new_max;
      pool_cnt <= completing ? '0 : pool_cnt + 1'b1;
      if (completing) begin
        out_cnt <= last_out ? '0 : out_cnt + 1'b1;
      end
    end
  end

  relu_pool_fifo #(
    .W     (WIDTH + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({new_max, last_out}),
    .full      (fifo_full),
    .pop       (m_ready_y),
    .pop_data  (head),
    .empty     (fifo_empty)
  );

  assign m_valid_y    = !fifo_empty;
  assign m_data_out_y = head[WIDTH:1];
  assign m_last_y     = head[0];

endmodule

// File: tb/tb_relu_maxpool_stream.sv
// Directed bench for relu_maxpool_stream: streams vectors, applies backpressure and reset.
module tb_relu_maxpool_stream;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] s_data_in_x;
  logic        s_valid_x;
  logic        s_ready_x;
  logic [15:0] m_data_out_y;
  logic        m_valid_y;
  logic        m_ready_y;
  logic        m_last_y;

  int n_checks = 0;
  int n_fail   = 0;
  int stalls   = 0;

  logic [15:0] out_data [$];
  logic        out_last [$];

  always #5 clk = ~clk;

  relu_maxpool_stream dut (
    .clk          (clk),
    .reset        (reset),
    .s_data_in_x  (s_data_in_x),
    .s_valid_x    (s_valid_x),
    .s_ready_x    (s_ready_x),
    .m_data_out_y (m_data_out_y),
    .m_valid_y    (m_valid_y),
    .m_ready_y    (m_ready_y),
    .m_last_y     (m_last_y)
  );

  // Inputs change just after posedge, so values at negedge predict the next edge's transfer.
  always @(negedge clk) begin
    if (!reset && m_valid_y && m_ready_y) begin
      out_data.push_back(m_data_out_y);
      out_last.push_back(m_last_y);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [15:0] v);
    int waited = 0;
    s_data_in_x = v;
    s_valid_x   = 1'b1;
    @(negedge clk);
    while (!s_ready_x && waited < 100) begin
      stalls++;
      waited++;
      @(negedge clk);
    end
    if (!s_ready_x) check("send_timeout", 32'(s_ready_x), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    s_valid_x   = 1'b0;
    s_data_in_x = '0;
    reset       = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_m_valid", 32'(m_valid_y), 0);
    check("rst_m_last", 32'(m_last_y), 0);
    check("rst_m_data", 32'(m_data_out_y), 0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_s_ready", 32'(s_ready_x), 1);
    out_data.delete();
    out_last.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(input int n, input string tag);
    int k = 0;
    while (out_data.size() < n && k < 300) begin
      @(posedge clk);
      k++;
    end
    repeat (4) @(posedge clk);
    #1;
    check(tag, out_data.size(), n);
  endtask

  function automatic logic [15:0] pat(input int i);
    int t;
    t = ((i * 7919 + 13) % 2001) - 1000;
    return t[15:0];
  endfunction

  function automatic int relu_m(input logic [15:0] v);
    return v[15] ? 0 : int'(v);
  endfunction

  initial begin
    int vals2 [10] = '{-5, -3, -5, 7, 7, -5, -32768, 32767, 3, 3};
    int exp2  [5]  = '{0, 7, 7, 32767, 3};
    int exp6  [3]  = '{100, 53, 59};
    int a, b, nlast;

    reset       = 1'b1;
    s_valid_x   = 1'b0;
    s_data_in_x = '0;
    m_ready_y   = 1'b0;

    // 1: ascending vector at full throughput
    do_reset();
    m_ready_y = 1'b1;
    stalls    = 0;
    for (int i = 1; i <= 24; i++) begin
      send(16'(i));
      if (i == 2) check("t1_latency_valid", 32'(m_valid_y), 1);
    end
    s_valid_x = 1'b0;
    wait_out(12, "t1_count");
    check("t1_no_stall", stalls, 0);
    for (int j = 0; j < 12; j++) begin
      check("t1_data", 32'(out_data[j]), 2 * (j + 1));
      check("t1_last", 32'(out_last[j]), (j == 11) ? 1 : 0);
    end

    // 2: signed pairs through ReLU and max
    do_reset();
    m_ready_y = 1'b1;
    for (int i = 0; i < 10; i++) send(16'(vals2[i]));
    s_valid_x = 1'b0;
    wait_out(5, "t2_count");
    for (int j = 0; j < 5; j++) begin
      check("t2_data", 32'(out_data[j]), exp2[j]);
      check("t2_last", 32'(out_last[j]), 0);
    end

    // 3: fill FIFO under backpressure, then drain
    do_reset();
    m_ready_y = 1'b0;
    for (int i = 1; i <= 9; i++) send(16'(i));
    s_valid_x = 1'b0;
    check("t3_s_ready_low", 32'(s_ready_x), 0);
    check("t3_head_valid", 32'(m_valid_y), 1);
    check("t3_head_data", 32'(m_data_out_y), 2);
    m_ready_y = 1'b1;
    for (int i = 10; i <= 24; i++) send(16'(i));
    s_valid_x = 1'b0;
    wait_out(12, "t3_count");
    for (int j = 0; j < 12; j++) begin
      check("t3_data", 32'(out_data[j]), 2 * (j + 1));
      check("t3_last", 32'(out_last[j]), (j == 11) ? 1 : 0);
    end

    // 4: two vectors, random downstream ready
    do_reset();
    fork
      begin
        for (int i = 0; i < 48; i++) send(pat(i));
        s_valid_x = 1'b0;
      end
      begin
        repeat (300) begin
          m_ready_y = 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
        end
        m_ready_y = 1'b1;
      end
    join
    wait_out(24, "t4_count");
    for (int j = 0; j < 24; j++) begin
      a = relu_m(pat(2 * j));
      b = relu_m(pat(2 * j + 1));
      check("t4_data", 32'(out_data[j]), (a > b) ? a : b);
      check("t4_last", 32'(out_last[j]), (j % 12 == 11) ? 1 : 0);
    end

    // 5: reset mid-vector with outputs queued
    do_reset();
    m_ready_y = 1'b0;
    for (int i = 1; i <= 7; i++) send(16'(i * 10));
    s_valid_x = 1'b0;
    check("t5_queued_valid", 32'(m_valid_y), 1);
    reset = 1'b1;
    #1;
    check("t5_async_valid", 32'(m_valid_y), 0);
    check("t5_async_last", 32'(m_last_y), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    out_data.delete();
    out_last.delete();
    m_ready_y = 1'b1;
    for (int i = 1; i <= 24; i++) send(16'(100 + i));
    s_valid_x = 1'b0;
    wait_out(12, "t5_count");
    check("t5_first", 32'(out_data[0]), 102);
    check("t5_final", 32'(out_data[11]), 124);
    check("t5_last12", 32'(out_last[11]), 1);
    nlast = 0;
    for (int j = 0; j < 11; j++) nlast += int'(out_last[j]);
    check("t5_early_last", nlast, 0);

    // 6: output held stable under backpressure while input has gaps
    do_reset();
    m_ready_y = 1'b0;
    send(16'd100);
    s_valid_x = 1'b0;
    @(posedge clk);
    #1;
    send(-16'sd4);
    check("t6_latency_valid", 32'(m_valid_y), 1);
    for (int k = 0; k < 10; k++) begin
      s_valid_x   = (k % 3 == 0);
      s_data_in_x = 16'(50 + k);
      @(negedge clk);
      check("t6_hold_valid", 32'(m_valid_y), 1);
      check("t6_hold_data", 32'(m_data_out_y), 100);
      check("t6_hold_last", 32'(m_last_y), 0);
      @(posedge clk);
      #1;
    end
    s_valid_x = 1'b0;
    m_ready_y = 1'b1;
    wait_out(3, "t6_count");
    for (int j = 0; j < 3; j++) check("t6_data", 32'(out_data[j]), exp6[j]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
